// File: rtl/page_table_walker.sv
// rtl/page_table_walker.sv - two-level page table walker producing TLB fill writes or page faults
// Serves one TLB miss at a time; a flush drains any outstanding read before returning to IDLE.
module page_table_walker #(
  parameter int VPN_WIDTH   = 20,
  parameter int PPN_WIDTH   = 20,
  parameter int PTE_WIDTH   = 32,
  parameter int PAGE_OFFSET = 12
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic [PPN_WIDTH-1:0]             ptbr_i,
  input  logic                             miss_valid_i,
  input  logic [VPN_WIDTH-1:0]             miss_vpn_i,
  output logic                             miss_ready_o,
  output logic                             mem_req_valid_o,
  input  logic                             mem_req_ready_i,
  output logic [PPN_WIDTH+PAGE_OFFSET-1:0] mem_req_addr_o,
  input  logic                             mem_resp_valid_i,
  input  logic [PTE_WIDTH-1:0]             mem_resp_data_i,
  output logic                             fill_wr_en_o,
  output logic [VPN_WIDTH-1:0]             fill_vpn_o,
  output logic [PPN_WIDTH-1:0]             fill_ppn_o,
  output logic                             fault_o,
  output logic [VPN_WIDTH-1:0]             fault_vpn_o,
  output logic                             busy_o
);

  localparam int ADDR_W = PPN_WIDTH + PAGE_OFFSET;
  localparam int V0_W   = VPN_WIDTH / 2;
  localparam int V1_W   = VPN_WIDTH - V0_W;
  localparam int SP_W   = PPN_WIDTH - V0_W;

  typedef enum logic [2:0] {
    IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, FILL, FAULT
  } state_t;

  state_t                state_q, state_d;
  logic [VPN_WIDTH-1:0]  vpn_q;
  logic [PPN_WIDTH-1:0]  ptbr_q;
  logic [PPN_WIDTH-1:0]  pte_ppn_q;
  logic                  drop_q;
  logic [VPN_WIDTH-1:0]  fill_vpn_q;
  logic [PPN_WIDTH-1:0]  fill_ppn_q;
  logic [VPN_WIDTH-1:0]  fault_vpn_q;

  logic                  pte_v;
  logic                  pte_l;
  logic [PPN_WIDTH-1:0]  resp_ppn;
  logic [PPN_WIDTH-1:0]  superpage_ppn;
  logic [V1_W-1:0]       vpn1;
  logic [V0_W-1:0]       vpn0;
  logic [ADDR_W-1:0]     l1_addr;
  logic [ADDR_W-1:0]     l0_addr;
  logic                  abort;
  logic                  unused_pte_bits;

  assign pte_v         = mem_resp_data_i[0];
  assign pte_l         = mem_resp_data_i[1];
  assign resp_ppn      = mem_resp_data_i[10 +: PPN_WIDTH];
  assign vpn1          = vpn_q[VPN_WIDTH-1 -: V1_W];
  assign vpn0          = vpn_q[V0_W-1:0];
  // A superpage maps VPN0 straight through below the PTE's upper PPN bits.
  assign superpage_ppn = {resp_ppn[PPN_WIDTH-1 -: SP_W], vpn0};
  assign l1_addr       = {ptbr_q, {PAGE_OFFSET{1'b0}}}
                       + {{(ADDR_W-V1_W-2){1'b0}}, vpn1, 2'b00};
  assign l0_addr       = {pte_ppn_q, {PAGE_OFFSET{1'b0}}}
                       + {{(ADDR_W-V0_W-2){1'b0}}, vpn0, 2'b00};
  assign abort         = drop_q | flush_i;
  assign unused_pte_bits = ^{mem_resp_data_i[PTE_WIDTH-1:PPN_WIDTH+10],
                             mem_resp_data_i[9:2]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      vpn_q       <= '0;
      ptbr_q      <= '0;
      pte_ppn_q   <= '0;
      drop_q      <= 1'b0;
      fill_vpn_q  <= '0;
      fill_ppn_q  <= '0;
      fault_vpn_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == L1_REQ) begin
        vpn_q  <= miss_vpn_i;
        ptbr_q <= ptbr_i;
        drop_q <= 1'b0;
      end else if (flush_i && state_q inside {L1_REQ, L1_WAIT, L0_REQ, L0_WAIT}) begin
        drop_q <= 1'b1;
      end
      if (state_q == L1_WAIT && state_d == L0_REQ) begin
        pte_ppn_q <= resp_ppn;
      end
      if (state_d == FILL) begin
        fill_vpn_q <= vpn_q;
        fill_ppn_q <= (state_q == L1_WAIT) ? superpage_ppn : resp_ppn;
      end
      if (state_d == FAULT) begin
        fault_vpn_q <= vpn_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss_valid_i && !flush_i) state_d = L1_REQ;
      L1_REQ: begin
        if (mem_req_ready_i)  state_d = L1_WAIT;
        else if (flush_i)     state_d = IDLE;
      end
      L1_WAIT: begin
        if (mem_resp_valid_i) begin
          if (abort)          state_d = IDLE;
          else if (!pte_v)    state_d = FAULT;
          else if (pte_l)     state_d = FILL;
          else                state_d = L0_REQ;
        end
      end
      L0_REQ: begin
        if (mem_req_ready_i)  state_d = L0_WAIT;
        else if (flush_i)     state_d = IDLE;
      end
      L0_WAIT: begin
        if (mem_resp_valid_i) begin
          if (abort)               state_d = IDLE;
          else if (pte_v && pte_l) state_d = FILL;
          else                     state_d = FAULT;
        end
      end
      FILL:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    miss_ready_o    = (state_q == IDLE);
    busy_o          = (state_q != IDLE);
    mem_req_valid_o = (state_q == L1_REQ) || (state_q == L0_REQ);
    mem_req_addr_o  = '0;
    if (state_q == L1_REQ) mem_req_addr_o = l1_addr;
    if (state_q == L0_REQ) mem_req_addr_o = l0_addr;
    fill_wr_en_o    = (state_q == FILL) && !flush_i;
    fault_o         = (state_q == FAULT) && !flush_i;
    fill_vpn_o      = fill_vpn_q;
    fill_ppn_o      = fill_ppn_q;
    fault_vpn_o     = fault_vpn_q;
  end

endmodule

// File: tb/tb_page_table_walker.sv
// tb/tb_page_table_walker.sv - randomized bench for page_table_walker against a behavioural walk model
// Memory is a scripted responder returning the PTEs supplied per walk with random stalls and delays.
module tb_page_table_walker;

  localparam int VW = 20;
  localparam int PW = 20;
  localparam int TW = 32;
  localparam int AW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i, flush_i, miss_valid_i, mem_req_ready_i, mem_resp_valid_i;
  logic [PW-1:0] ptbr_i;
  logic [VW-1:0] miss_vpn_i;
  logic [TW-1:0] mem_resp_data_i;
  logic          miss_ready_o, mem_req_valid_o, fill_wr_en_o, fault_o, busy_o;
  logic [AW-1:0] mem_req_addr_o;
  logic [VW-1:0] fill_vpn_o, fault_vpn_o;
  logic [PW-1:0] fill_ppn_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  page_table_walker dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .ptbr_i(ptbr_i),
    .miss_valid_i(miss_valid_i), .miss_vpn_i(miss_vpn_i), .miss_ready_o(miss_ready_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_resp_valid_i(mem_resp_valid_i),
    .mem_resp_data_i(mem_resp_data_i), .fill_wr_en_o(fill_wr_en_o),
    .fill_vpn_o(fill_vpn_o), .fill_ppn_o(fill_ppn_o), .fault_o(fault_o),
    .fault_vpn_o(fault_vpn_o), .busy_o(busy_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [AW-1:0] pte_addr(input int unsigned base, input int unsigned idx);
    longint unsigned a;
    a = longint'(base) * 4096 + longint'(idx) * 4;
    return a[AW-1:0];
  endfunction

  // Reference walk: which reads happen, and whether it ends in a fill (with what PPN) or a fault.
  task automatic model_walk(input int unsigned ptbr, input int unsigned vpn,
                            input int unsigned pte1, input int unsigned pte0,
                            output int levels, output bit fault,
                            output logic [PW-1:0] ppn, output logic [AW-1:0] a1,
                            output logic [AW-1:0] a0);
    int unsigned vpn1, vpn0, ppn1, ppn0, res;
    vpn1 = vpn / 1024;
    vpn0 = vpn % 1024;
    ppn1 = (pte1 / 1024) % (1 << 20);
    ppn0 = (pte0 / 1024) % (1 << 20);
    a1 = pte_addr(ptbr, vpn1);
    a0 = pte_addr(ppn1, vpn0);
    res = 0;
    if (pte1 % 2 == 0) begin
      levels = 1; fault = 1'b1;
    end else if ((pte1 / 2) % 2 == 1) begin
      levels = 1; fault = 1'b0; res = (ppn1 / 1024) * 1024 + vpn0;
    end else begin
      levels = 2; fault = !(pte0 % 4 == 3); res = ppn0;
    end
    ppn = res[PW-1:0];
  endtask

  task automatic run_walk(input logic [PW-1:0] ptbr, input logic [VW-1:0] vpn,
                          input logic [TW-1:0] pte1, input logic [TW-1:0] pte0,
                          input int min_stall, input int max_stall, input int max_delay,
                          input bit check_lat);
    int levels, reqs, stall, delay;
    bit exp_fault, pending, done;
    logic [PW-1:0] exp_ppn;
    logic [AW-1:0] a1, a0;
    model_walk(ptbr, vpn, pte1, pte0, levels, exp_fault, exp_ppn, a1, a0);
    reqs = 0; delay = 0; pending = 1'b0; done = 1'b0;
    check_eq("miss_ready_idle", miss_ready_o, 1);
    ptbr_i = ptbr; miss_vpn_i = vpn; miss_valid_i = 1'b1;
    tick;
    miss_valid_i = 1'b0;
    ptbr_i = PW'($urandom);
    miss_vpn_i = VW'($urandom);
    stall = $urandom_range(max_stall, min_stall);
    for (int cyc = 1; cyc < 200 && !done; cyc++) begin
      mem_resp_valid_i = 1'b0;
      mem_resp_data_i = $urandom;
      if (pending) begin
        if (delay == 0) begin
          mem_resp_valid_i = 1'b1;
          mem_resp_data_i = (reqs == 1) ? pte1 : pte0;
          pending = 1'b0;
        end else begin
          delay--;
        end
      end
      if (fill_wr_en_o || fault_o) begin
        done = 1'b1;
        check_eq("pulse_exclusive", fill_wr_en_o & fault_o, 0);
        check_eq("outcome_fault", fault_o, exp_fault);
        check_eq("read_count", reqs, levels);
        if (exp_fault) begin
          check_eq("fault_vpn", fault_vpn_o, vpn);
        end else begin
          check_eq("fill_vpn", fill_vpn_o, vpn);
          check_eq("fill_ppn", fill_ppn_o, exp_ppn);
        end
        if (check_lat) check_eq("latency", cyc, (levels == 1) ? 3 : 5);
      end else begin
        check_eq("busy_walk", busy_o, 1);
        check_eq("miss_ready_walk", miss_ready_o, 0);
        if (mem_req_valid_o) begin
          check_eq("req_addr", mem_req_addr_o, (reqs == 0) ? a1 : a0);
          if (stall > 0) begin
            mem_req_ready_i = 1'b0;
            stall--;
          end else begin
            mem_req_ready_i = 1'b1;
            reqs++;
            pending = 1'b1;
            delay = $urandom_range(max_delay, 0);
            stall = $urandom_range(max_stall, min_stall);
          end
        end else begin
          mem_req_ready_i = 1'($urandom);
        end
      end
      tick;
    end
    check_eq("walk_done", done, 1);
    mem_resp_valid_i = 1'b0;
    check_eq("post_busy", busy_o, 0);
    check_eq("post_pulses", {fill_wr_en_o, fault_o}, 0);
    if (!exp_fault) check_eq("fill_ppn_hold", fill_ppn_o, exp_ppn);
  endtask

  initial begin
    logic [TW-1:0] p1, p0;
    int kind;
    rst_i = 1'b1; flush_i = 1'b0; miss_valid_i = 1'b0; mem_req_ready_i = 1'b0;
    mem_resp_valid_i = 1'b0; mem_resp_data_i = '0; ptbr_i = '0; miss_vpn_i = '0;
    repeat (3) tick;
    rst_i = 1'b0;
    check_eq("rst_miss_ready", miss_ready_o, 1);
    check_eq("rst_outputs", {mem_req_valid_o, mem_req_addr_o, fill_wr_en_o, fill_vpn_o,
                             fill_ppn_o, fault_o, fault_vpn_o, busy_o}, 0);

    // Zero-wait directed walks with latency checks.
    run_walk(20'h00100, 20'h00403, 32'h00200001, 32'h0ABCD003, 0, 0, 0, 1);
    run_walk(20'h00100, 20'h00403, 32'h12C00003, 32'h0, 0, 0, 0, 1);
    run_walk(20'h00100, 20'h00403, 32'h00000000, 32'h0, 0, 0, 0, 1);
    run_walk(20'h00100, 20'h00403, 32'h00200001, 32'h00000001, 0, 0, 0, 1);
    // Four-cycle request backpressure at both levels.
    run_walk(20'h00777, 20'hFFFFF, 32'h3FFFFC01, 32'hFFFFFFFF, 4, 4, 0, 0);

    // Flush while waiting on L1: response must be drained with no outcome.
    miss_vpn_i = 20'h00403; ptbr_i = 20'h00100; miss_valid_i = 1'b1;
    tick;
    miss_valid_i = 1'b0; mem_req_ready_i = 1'b1;
    tick;
    mem_req_ready_i = 1'b0; flush_i = 1'b1;
    tick;
    flush_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_eq("flush_wait_noreq", mem_req_valid_o, 0);
      check_eq("flush_wait_busy", busy_o, 1);
      check_eq("flush_wait_pulses", {fill_wr_en_o, fault_o}, 0);
      tick;
    end
    mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'h12C00003;
    check_eq("flush_resp_pulses", {fill_wr_en_o, fault_o}, 0);
    tick;
    mem_resp_valid_i = 1'b0;
    check_eq("flush_wait_idle", {busy_o, miss_ready_o}, 2'b01);
    check_eq("flush_wait_after", {fill_wr_en_o, fault_o, mem_req_valid_o}, 0);

    // Flush in L1_REQ without a handshake.
    miss_valid_i = 1'b1;
    tick;
    miss_valid_i = 1'b0;
    check_eq("l1req_valid", mem_req_valid_o, 1);
    mem_req_ready_i = 1'b0; flush_i = 1'b1;
    tick;
    flush_i = 1'b0;
    check_eq("flush_req_idle", {busy_o, miss_ready_o, mem_req_valid_o}, 3'b010);

    // Flush during FILL suppresses the strobe.
    miss_valid_i = 1'b1;
    tick;
    miss_valid_i = 1'b0; mem_req_ready_i = 1'b1;
    tick;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'h12C00003;
    tick;
    mem_resp_valid_i = 1'b0; flush_i = 1'b1;
    #1;
    check_eq("flush_fill_busy", busy_o, 1);
    check_eq("flush_fill_suppressed", {fill_wr_en_o, fault_o}, 0);
    tick;
    flush_i = 1'b0;
    check_eq("flush_fill_idle", {busy_o, fill_wr_en_o, fault_o}, 0);

    // Reset in L0_WAIT, then a stray response in IDLE.
    miss_vpn_i = 20'h00403; ptbr_i = 20'h00100; miss_valid_i = 1'b1;
    tick;
    miss_valid_i = 1'b0; mem_req_ready_i = 1'b1;
    tick;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'h00200001;
    tick;
    mem_resp_valid_i = 1'b0; mem_req_ready_i = 1'b1;
    tick;
    mem_req_ready_i = 1'b0;
    check_eq("l0wait_busy", {busy_o, mem_req_valid_o}, 2'b10);
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    check_eq("midrst_miss_ready", miss_ready_o, 1);
    check_eq("midrst_outputs", {mem_req_valid_o, mem_req_addr_o, fill_wr_en_o, fill_vpn_o,
                                fill_ppn_o, fault_o, fault_vpn_o, busy_o}, 0);
    mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'h0ABCD003;
    tick;
    mem_resp_valid_i = 1'b0;
    check_eq("stray_resp_ignored", {busy_o, fill_wr_en_o, fault_o, miss_ready_o}, 4'b0001);
    run_walk(20'h00100, 20'h00403, 32'h00200001, 32'h0ABCD003, 0, 0, 0, 1);

    // Randomized walks, issued back to back.
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(4, 0);
      p1 = $urandom;
      p0 = $urandom;
      case (kind)
        0:       p1[0] = 1'b0;
        1:       p1[1:0] = 2'b11;
        2:       begin p1[1:0] = 2'b01; p0[1:0] = 2'b11; end
        default: p1[1:0] = 2'b01;
      endcase
      run_walk(PW'($urandom), VW'($urandom), p1, p0, 0, 3, 3, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
